// File: rtl/core_mem_access.sv
// MEM-stage data-memory access unit: turns EX/MEM load/store controls into a
// req/gnt/rvalid data-bus transaction, formats load data and stalls the pipe.
module core_mem_access #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [2:0]        read_type_i,
   input  logic [1:0]        write_type_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              dbus_req_o,
   output logic              dbus_we_o,
   output logic [ADDR_W-1:0] dbus_addr_o,
   output logic [DATA_W-1:0] dbus_wdata_o,
   output logic [7:0]        dbus_wstrb_o,
   input  logic              dbus_gnt_i,
   input  logic              dbus_rvalid_i,
   input  logic [DATA_W-1:0] dbus_rdata_i,
   output logic [DATA_W-1:0] load_data_o,
   output logic              stall_o,
   output logic              misalign_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        rtype_q, rtype_d;
   logic [2:0]        off_q, off_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        wstrb_q, wstrb_d;
   logic [DATA_W-1:0] load_q, load_d;

   logic       access;
   logic [1:0] size;
   logic [2:0] off;
   logic       misaligned;
   logic [7:0] strb;

   // Shift the addressed lane down, then extend according to the load funct3.
   function automatic logic [DATA_W-1:0] fmt_load(input logic [2:0]        rtype,
                                                  input logic [2:0]        boff,
                                                  input logic [DATA_W-1:0] rdata);
      logic [DATA_W-1:0] field;
      field = rdata >> {boff, 3'b000};
      case (rtype)
         3'b000:  fmt_load = {{(DATA_W-8){field[7]}}, field[7:0]};
         3'b001:  fmt_load = {{(DATA_W-16){field[15]}}, field[15:0]};
         3'b010:  fmt_load = {{(DATA_W-32){field[31]}}, field[31:0]};
         3'b100:  fmt_load = {{(DATA_W-8){1'b0}}, field[7:0]};
         3'b101:  fmt_load = {{(DATA_W-16){1'b0}}, field[15:0]};
         3'b110:  fmt_load = {{(DATA_W-32){1'b0}}, field[31:0]};
         default: fmt_load = field;
      endcase
   endfunction

   // Access decode; a load's size is funct3[1:0], which also maps 111 onto LD.
   always_comb begin
      access = mem_read_i | mem_write_i;
      size   = mem_write_i ? write_type_i : read_type_i[1:0];
      off    = addr_i[2:0];
      case (size)
         2'b00:   begin misaligned = 1'b0;       strb = 8'h01 << off; end
         2'b01:   begin misaligned = off[0];     strb = 8'h03 << off; end
         2'b10:   begin misaligned = |off[1:0];  strb = 8'h0F << off; end
         default: begin misaligned = |off;       strb = 8'hFF;        end
      endcase
   end

   // NOTE: every signal gets its hold value first so no path through the case
   // leaves one unassigned; that is what keeps this block free of latches.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      rtype_d = rtype_q;
      off_d   = off_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      load_d  = load_q;
      case (state_q)
         S_IDLE: begin
            if (access && !misaligned) begin
               we_d    = mem_write_i;
               rtype_d = read_type_i;
               off_d   = off;
               addr_d  = {addr_i[ADDR_W-1:3], 3'b000};
               wdata_d = wdata_i << {off, 3'b000};
               wstrb_d = strb;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (dbus_gnt_i) begin
               if (we_q) begin
                  state_d = S_DONE;
               end else if (dbus_rvalid_i) begin
                  load_d  = fmt_load(rtype_q, off_q, dbus_rdata_i);
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (dbus_rvalid_i) begin
               load_d  = fmt_load(rtype_q, off_q, dbus_rdata_i);
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         rtype_q <= 3'b000;
         off_q   <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= 8'h00;
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         rtype_q <= rtype_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         load_q  <= load_d;
      end
   end

   assign dbus_req_o   = (state_q == S_REQ);
   assign dbus_we_o    = we_q;
   assign dbus_addr_o  = addr_q;
   assign dbus_wdata_o = wdata_q;
   assign dbus_wstrb_o = wstrb_q;
   assign load_data_o  = load_q;
   assign misalign_o   = (state_q == S_IDLE) && access && misaligned;
   assign stall_o      = ((state_q == S_IDLE) && access && !misaligned)
                       || (state_q == S_REQ) || (state_q == S_WAIT);

endmodule

// File: tb/tb_core_mem_access.sv
// Table-driven bench for core_mem_access with a responding bus model and an
// expected-load-data scoreboard queue.
module tb_core_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_i, mem_write_i;
   logic [2:0]  read_type_i;
   logic [1:0]  write_type_i;
   logic [63:0] addr_i, wdata_i;
   logic        dbus_req_o, dbus_we_o;
   logic [63:0] dbus_addr_o, dbus_wdata_o;
   logic [7:0]  dbus_wstrb_o;
   logic        dbus_gnt_i, dbus_rvalid_i;
   logic [63:0] dbus_rdata_i;
   logic [63:0] load_data_o;
   logic        stall_o, misalign_o;

   core_mem_access #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read_i   (mem_read_i),
      .mem_write_i  (mem_write_i),
      .read_type_i  (read_type_i),
      .write_type_i (write_type_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .dbus_req_o   (dbus_req_o),
      .dbus_we_o    (dbus_we_o),
      .dbus_addr_o  (dbus_addr_o),
      .dbus_wdata_o (dbus_wdata_o),
      .dbus_wstrb_o (dbus_wstrb_o),
      .dbus_gnt_i   (dbus_gnt_i),
      .dbus_rvalid_i(dbus_rvalid_i),
      .dbus_rdata_i (dbus_rdata_i),
      .load_data_o  (load_data_o),
      .stall_o      (stall_o),
      .misalign_o   (misalign_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [2:0]  rtype;
      logic [1:0]  wtype;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          gdly;   // REQ cycles without gnt
      int          rdly;   // cycles from gnt to rvalid (0 = same cycle)
      logic [7:0]  exp_strb;
      logic [63:0] exp_wdata;
      logic [63:0] exp_load;
      int          exp_stall;
   } vec_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_load = 64'h0;
   vec_t        vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      mem_read_i   = 1'b0;
      mem_write_i  = 1'b0;
      read_type_i  = 3'b000;
      write_type_i = 2'b00;
      addr_i       = 64'h0;
      wdata_i      = 64'h0;
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      int  stalls = 0;
      int  reqs   = 0;
      int  gnt_at = -1;
      bit  done   = 1'b0;
      logic [63:0] exp_load;
      @(negedge clk);
      mem_read_i   = v.rd;
      mem_write_i  = v.wr;
      read_type_i  = v.rtype;
      write_type_i = v.wtype;
      addr_i       = v.addr;
      wdata_i      = v.wdata;
      dbus_rdata_i = v.rdata;
      if (!v.wr) last_load = v.exp_load;
      exp_q.push_back(last_load);
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         dbus_gnt_i    = 1'b0;
         dbus_rvalid_i = 1'b0;
         #1;
         if (stall_o) stalls++;
         if (dbus_req_o) begin
            check($sformatf("v%0d_addr", idx), dbus_addr_o, v.addr & ~64'h7);
            check($sformatf("v%0d_we", idx), {63'h0, dbus_we_o}, {63'h0, v.wr});
            if (v.wr) begin
               check($sformatf("v%0d_wstrb", idx), {56'h0, dbus_wstrb_o}, {56'h0, v.exp_strb});
               check($sformatf("v%0d_wdata", idx), dbus_wdata_o, v.exp_wdata);
            end
            if (reqs == v.gdly) begin
               dbus_gnt_i = 1'b1;
               gnt_at     = cyc;
               if (!v.wr && v.rdly == 0) dbus_rvalid_i = 1'b1;
            end
            reqs++;
         end else if (!stall_o) begin
            if (gnt_at >= 0) begin
               done     = 1'b1;
               exp_load = exp_q.pop_front();
               check($sformatf("v%0d_load_data", idx), load_data_o, exp_load);
               check($sformatf("v%0d_stall_cycles", idx), 64'(stalls), 64'(v.exp_stall));
               idle_inputs();
            end
         end else if (gnt_at >= 0) begin
            if (cyc - gnt_at == v.rdly) dbus_rvalid_i = 1'b1;
         end else if (cyc == 0) begin
            check($sformatf("v%0d_idle_misalign", idx), {63'h0, misalign_o}, 64'h0);
         end
         if (!done) @(negedge clk);
      end
      if (!done) begin
         check($sformatf("v%0d_timeout", idx), 64'h0, 64'h1);
         void'(exp_q.pop_front());
         idle_inputs();
         dbus_gnt_i    = 1'b0;
         dbus_rvalid_i = 1'b0;
      end
   endtask

   task automatic check_misaligned(input string name, input bit rd, input bit wr,
                                   input logic [2:0] rt, input logic [1:0] wt,
                                   input logic [63:0] addr);
      @(negedge clk);
      mem_read_i   = rd;
      mem_write_i  = wr;
      read_type_i  = rt;
      write_type_i = wt;
      addr_i       = addr;
      #1;
      check({name, "_misalign"}, {63'h0, misalign_o}, 64'h1);
      check({name, "_req"}, {63'h0, dbus_req_o}, 64'h0);
      check({name, "_stall"}, {63'h0, stall_o}, 64'h0);
      @(negedge clk);
      #1;
      check({name, "_req_later"}, {63'h0, dbus_req_o}, 64'h0);
      check({name, "_stall_later"}, {63'h0, stall_o}, 64'h0);
      idle_inputs();
   endtask

   initial begin
      //          rd wr rtype  wtype  addr          wdata                  rdata                  g  r  strb   exp_wdata              exp_load               stall
      vecs[0]  = '{1, 0, 3'b011, 2'b00, 64'h1000, 64'h0,                 64'h0123456789ABCDEF, 0, 0, 8'h00, 64'h0,                 64'h0123456789ABCDEF, 2};
      vecs[1]  = '{1, 0, 3'b000, 2'b00, 64'h2007, 64'h0,                 64'h8011223344556677, 0, 0, 8'h00, 64'h0,                 64'hFFFFFFFFFFFFFF80, 2};
      vecs[2]  = '{1, 0, 3'b100, 2'b00, 64'h2007, 64'h0,                 64'h8011223344556677, 0, 0, 8'h00, 64'h0,                 64'h0000000000000080, 2};
      vecs[3]  = '{1, 0, 3'b010, 2'b00, 64'h2004, 64'h0,                 64'h8000000112345678, 1, 1, 8'h00, 64'h0,                 64'hFFFFFFFF80000001, 4};
      vecs[4]  = '{1, 0, 3'b110, 2'b00, 64'h2004, 64'h0,                 64'h8000000112345678, 0, 2, 8'h00, 64'h0,                 64'h0000000080000001, 4};
      vecs[5]  = '{1, 0, 3'b001, 2'b00, 64'h2002, 64'h0,                 64'h11112222F00D3333, 0, 1, 8'h00, 64'h0,                 64'hFFFFFFFFFFFFF00D, 3};
      vecs[6]  = '{1, 0, 3'b101, 2'b00, 64'h2006, 64'h0,                 64'h11112222F00D3333, 0, 0, 8'h00, 64'h0,                 64'h0000000000001111, 2};
      vecs[7]  = '{1, 0, 3'b111, 2'b00, 64'h1008, 64'h0,                 64'hDEADBEEFCAFEF00D, 2, 2, 8'h00, 64'h0,                 64'hDEADBEEFCAFEF00D, 6};
      vecs[8]  = '{0, 1, 3'b000, 2'b01, 64'h3002, 64'h000000000000BEEF, 64'h0,                 0, 0, 8'h0C, 64'h00000000BEEF0000, 64'h0,                 2};
      vecs[9]  = '{0, 1, 3'b000, 2'b00, 64'h3005, 64'h123456789ABCDEAB, 64'h0,                 3, 0, 8'h20, 64'hBCDEAB0000000000, 64'h0,                 5};
      vecs[10] = '{0, 1, 3'b000, 2'b10, 64'h3004, 64'h00000000CAFEBABE, 64'h0,                 1, 0, 8'hF0, 64'hCAFEBABE00000000, 64'h0,                 3};
      vecs[11] = '{1, 1, 3'b011, 2'b11, 64'h3010, 64'h0102030405060708, 64'hFFFFFFFFFFFFFFFF, 0, 0, 8'hFF, 64'h0102030405060708, 64'h0,                 2};

      rst           = 1'b1;
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      dbus_rdata_i  = 64'h0;
      idle_inputs();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_req", {63'h0, dbus_req_o}, 64'h0);
      check("rst_we", {63'h0, dbus_we_o}, 64'h0);
      check("rst_addr", dbus_addr_o, 64'h0);
      check("rst_wdata", dbus_wdata_o, 64'h0);
      check("rst_wstrb", {56'h0, dbus_wstrb_o}, 64'h0);
      check("rst_load_data", load_data_o, 64'h0);
      check("rst_stall", {63'h0, stall_o}, 64'h0);
      check("rst_misalign", {63'h0, misalign_o}, 64'h0);

      for (int i = 0; i < 12; i++) run_txn(i, vecs[i]);

      check_misaligned("lw_4002", 1'b1, 1'b0, 3'b010, 2'b00, 64'h4002);
      check_misaligned("sd_4004", 1'b0, 1'b1, 3'b000, 2'b11, 64'h4004);
      check_misaligned("lh_4001", 1'b1, 1'b0, 3'b101, 2'b00, 64'h4001);

      // Reset while a load waits for rvalid; a late rvalid must be ignored.
      @(negedge clk);
      mem_read_i  = 1'b1;
      read_type_i = 3'b011;
      addr_i      = 64'h5000;
      @(negedge clk);
      #1;
      check("rstw_req", {63'h0, dbus_req_o}, 64'h1);
      dbus_gnt_i = 1'b1;
      @(negedge clk);
      dbus_gnt_i = 1'b0;
      #1;
      check("rstw_in_wait_stall", {63'h0, stall_o}, 64'h1);
      check("rstw_in_wait_req", {63'h0, dbus_req_o}, 64'h0);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstw_after_req", {63'h0, dbus_req_o}, 64'h0);
      check("rstw_after_stall", {63'h0, stall_o}, 64'h0);
      check("rstw_after_load", load_data_o, 64'h0);
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 64'hA5A5A5A5A5A5A5A5;
      @(negedge clk);
      dbus_rvalid_i = 1'b0;
      #1;
      check("rstw_late_rvalid_load", load_data_o, 64'h0);
      check("rstw_late_rvalid_req", {63'h0, dbus_req_o}, 64'h0);
      check("rstw_late_rvalid_stall", {63'h0, stall_o}, 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
